multicycle_seq_ctrl: RTL

- Multi-cycle sequencer for the 4-bit-instruction processor datapath.
- Replaces free-running single-cycle issue with a FETCH/DECODE/EXECUTE/WRITEBACK FSM.
- Handshakes with the IFU for each instruction and latches it into an instruction register (IR).
- Drives register addresses, ALU control/enable and a one-cycle regwrite pulse into DATAPATH; reports halt, timeout error and retired-instruction count.

---
 rtl/multicycle_seq_ctrl_if.sv | 38 +++
 rtl/multicycle_seq_ctrl.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/multicycle_seq_ctrl_if.sv
// Handshake/control bundle between the multi-cycle sequencer and its
// surroundings (IFU, DATAPATH, status observers).
// The master modport is the sequencer side; the slave modport is the
// environment side that drives start/stop/instruction/zero.
interface multicycle_seq_ctrl_if #(
    parameter int RET_W = 8
);
    logic             start;
    logic             stop;
    logic             instr_valid;
    logic             instr_ready;
    logic [3:0]       instr_code;
    logic             zero;
    logic [1:0]       rs1_addr;
    logic [1:0]       rs2_addr;
    logic [1:0]       rd_addr;
    logic [1:0]       alu_control;
    logic             alu_en;
    logic             regwrite;
    logic             zero_q;
    logic             busy;
    logic             done;
    logic             err;
    logic [RET_W-1:0] retired;
    logic [15:0]      stall_cnt;

    modport master (
        input  start, stop, instr_valid, instr_code, zero,
        output instr_ready, rs1_addr, rs2_addr, rd_addr, alu_control,
               alu_en, regwrite, zero_q, busy, done, err, retired, stall_cnt
    );

    modport slave (
        output start, stop, instr_valid, instr_code, zero,
        input  instr_ready, rs1_addr, rs2_addr, rd_addr, alu_control,
               alu_en, regwrite, zero_q, busy, done, err, retired, stall_cnt
    );
endinterface

// File: rtl/multicycle_seq_ctrl.sv
// Multi-cycle sequencer for the 4-bit-instruction datapath.
// Each instruction goes FETCH -> DECODE -> EXECUTE -> WRITEBACK; opcode 0
// is a NOP that retires from DECODE, opcode F halts.  A FETCH that waits
// TIMEOUT cycles without a valid instruction parks the sequencer in a
// sticky ERROR state.  Every output is a function of registered state only.
// Optional feature macro: SEQ_STALL_CNT_EN enables the saturating FETCH
// stall-cycle counter; without it stall_cnt is constant zero.
module multicycle_seq_ctrl #(
    parameter int RET_W   = 8,
    parameter int TIMEOUT = 15
) (
    input  logic                  clock,
    input  logic                  reset,
    multicycle_seq_ctrl_if.master bus
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_WRITEBACK,
        S_HALT,
        S_ERROR
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       ir_q, ir_d;
    logic             zero_q, zero_d;
    logic [TW-1:0]    tmo_q, tmo_d;
    logic [RET_W-1:0] retired_q;
    logic             retirePulse;

    // State, instruction register, captured zero flag and FETCH wait counter
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            ir_q    <= 4'h0;
            zero_q  <= 1'b0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            zero_q  <= zero_d;
            tmo_q   <= tmo_d;
        end
    end

    // Next-state logic: handshake, decode dispatch, timeout and boundary stop
    always_comb begin
        state_d     = state_q;
        ir_d        = ir_q;
        zero_d      = zero_q;
        tmo_d       = '0;
        retirePulse = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) state_d = S_FETCH;
            end
            S_FETCH: begin
                if (bus.instr_valid) begin
                    ir_d    = bus.instr_code;
                    state_d = S_DECODE;
                end else if (tmo_q == TMO_LAST) begin
                    state_d = S_ERROR;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            S_DECODE: begin
                if (ir_q == 4'hF) begin
                    state_d = S_HALT;
                end else if (ir_q == 4'h0) begin
                    retirePulse = 1'b1;
                    state_d     = bus.stop ? S_IDLE : S_FETCH;
                end else begin
                    state_d = S_EXECUTE;
                end
            end
            S_EXECUTE: begin
                zero_d  = bus.zero;
                state_d = S_WRITEBACK;
            end
            S_WRITEBACK: begin
                retirePulse = 1'b1;
                state_d     = bus.stop ? S_IDLE : S_FETCH;
            end
            S_HALT: begin
                if (bus.start) state_d = S_FETCH;
            end
            S_ERROR: begin
                state_d = S_ERROR;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Retired-instruction counter, saturating at all ones
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            retired_q <= '0;
        end else if (retirePulse && (retired_q != {RET_W{1'b1}})) begin
            retired_q <= retired_q + RET_W'(1);
        end
    end

`ifdef SEQ_STALL_CNT_EN
    logic [15:0] stall_q;

    // FETCH stall-cycle counter, saturating, cleared only by reset
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_q <= 16'h0000;
        end else if ((state_q == S_FETCH) && !bus.instr_valid && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign bus.stall_cnt = stall_q;
`else
    assign bus.stall_cnt = 16'h0000;
`endif

    assign bus.instr_ready = (state_q == S_FETCH);
    assign bus.rs1_addr    = ir_q[2:1];
    assign bus.rs2_addr    = ir_q[3:2];
    assign bus.rd_addr     = ir_q[1:0];
    assign bus.alu_en      = (state_q == S_EXECUTE);
    assign bus.alu_control = (state_q == S_EXECUTE) ? ir_q[3:2] : 2'b00;
    assign bus.regwrite    = (state_q == S_WRITEBACK);
    assign bus.zero_q      = zero_q;
    assign bus.busy        = (state_q == S_FETCH) || (state_q == S_DECODE) ||
                             (state_q == S_EXECUTE) || (state_q == S_WRITEBACK);
    assign bus.done        = (state_q == S_HALT);
    assign bus.err         = (state_q == S_ERROR);
    assign bus.retired     = retired_q;

endmodule
